cpu_run_ctrl: RTL and testbench

- Run-control sequencer for the single-cycle MIPS core. It produces the per-cycle `commit` enable, which gates PC update, register write and memory write.
- Implements idle / free-run / single-step / halted states, driven by the control unit's `Halt` (syscall) and by two board buttons.
- Keeps saturating performance counters for committed instructions, taken jumps, taken branches and halts, for display on the IO panel.

---
 rtl/cpu_run_ctrl.sv | 118 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-cycle MIPS core: gates commit (PC/REG/MEM
// enables) through idle/run/pause/halt states and keeps saturating perf counters.
module cpu_run_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             step,
    input  logic             step_mode,
    input  logic             clr,
    input  logic             Halt,
    input  logic             Branch,
    input  logic             Z,
    input  logic             TargettoPC,
    input  logic             RStoPC,
    output logic             commit,
    output logic [1:0]       run_state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] halt_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_n;
    logic   go_q, step_q;
    logic   go_p, step_p;
    logic   enter_halt;
    logic   is_jump, is_branch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Edge registers reset high so a button held through reset produces no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_q   <= 1'b1;
            step_q <= 1'b1;
        end else begin
            go_q   <= go;
            step_q <= step;
        end
    end

    assign go_p   = go & ~go_q;
    assign step_p = step & ~step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (go_p) state_n = step_mode ? PAUSE : RUN;
            end
            RUN: begin
                // The syscall itself never commits, so PC stays parked on it.
                commit = ~Halt;
                if (Halt)           state_n = HALT;
                else if (step_mode) state_n = PAUSE;
            end
            PAUSE: begin
                commit = step_p & ~Halt;
                if (Halt)                    state_n = HALT;
                else if (go_p && !step_mode) state_n = RUN;
            end
            HALT: begin
                // Resume commits once to step PC past the syscall, even with Halt high.
                if (go_p) begin
                    commit  = 1'b1;
                    state_n = step_mode ? PAUSE : RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign run_state  = state;
    assign halted     = (state == HALT);
    assign enter_halt = (state_n == HALT) && (state != HALT);
    assign is_jump    = commit & (TargettoPC | RStoPC);
    assign is_branch  = commit & Branch & Z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt  <= '0;
            jump_cnt   <= '0;
            branch_cnt <= '0;
            halt_cnt   <= '0;
        end else if (clr) begin
            cycle_cnt  <= '0;
            jump_cnt   <= '0;
            branch_cnt <= '0;
            halt_cnt   <= '0;
        end else begin
            if (commit)     cycle_cnt  <= sat_inc(cycle_cnt);
            if (is_jump)    jump_cnt   <= sat_inc(jump_cnt);
            if (is_branch)  branch_cnt <= sat_inc(branch_cnt);
            if (enter_halt) halt_cnt   <= sat_inc(halt_cnt);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a 32-bit instance plus a 4-bit instance sharing
// stimulus, used to check counter saturation.
module tb_cpu_run_ctrl;

    logic clk = 1'b0;
    logic rst_n, go, step, step_mode, clr, Halt, Branch, Z, TargettoPC, RStoPC;

    logic        commit, halted;
    logic [1:0]  run_state;
    logic [31:0] cycle_cnt, jump_cnt, branch_cnt, halt_cnt;

    logic        commit4, halted4;
    logic [1:0]  run_state4;
    logic [3:0]  cycle_cnt4, jump_cnt4, branch_cnt4, halt_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .step(step), .step_mode(step_mode),
        .clr(clr), .Halt(Halt), .Branch(Branch), .Z(Z), .TargettoPC(TargettoPC),
        .RStoPC(RStoPC), .commit(commit), .run_state(run_state), .halted(halted),
        .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt), .branch_cnt(branch_cnt),
        .halt_cnt(halt_cnt)
    );

    cpu_run_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .go(go), .step(step), .step_mode(step_mode),
        .clr(clr), .Halt(Halt), .Branch(Branch), .Z(Z), .TargettoPC(TargettoPC),
        .RStoPC(RStoPC), .commit(commit4), .run_state(run_state4), .halted(halted4),
        .cycle_cnt(cycle_cnt4), .jump_cnt(jump_cnt4), .branch_cnt(branch_cnt4),
        .halt_cnt(halt_cnt4)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        go = 0; step = 0; step_mode = 0; clr = 0; Halt = 0;
        Branch = 0; Z = 0; TargettoPC = 0; RStoPC = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick(2);
        rst_n = 1;
        tick(1);
    endtask

    task automatic press_go();
        go = 1;
        tick(1);
        go = 0;
    endtask

    task automatic test_reset_and_run();
        clear_inputs();
        go = 1;
        rst_n = 0;
        tick(3);
        checks++; if (run_state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", run_state); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL rst_commit got=%0b exp=0", commit); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%0b exp=0", halted); end
        checks++; if ({cycle_cnt, jump_cnt, branch_cnt, halt_cnt} !== 128'd0) begin
            errors++; $display("FAIL rst_counters got=%0h/%0h/%0h/%0h exp=0", cycle_cnt, jump_cnt, branch_cnt, halt_cnt);
        end
        rst_n = 1;
        tick(2);
        checks++; if (run_state !== 2'd0) begin errors++; $display("FAIL held_go_no_fire got=%0d exp=0", run_state); end
        go = 0;
        tick(1);
        press_go();
        checks++; if (run_state !== 2'd1) begin errors++; $display("FAIL go_to_run got=%0d exp=1", run_state); end
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL idle_no_commit got=%0d exp=0", cycle_cnt); end
        tick(10);
        checks++; if (cycle_cnt !== 32'd10) begin errors++; $display("FAIL run10_cycles got=%0d exp=10", cycle_cnt); end
    endtask

    task automatic test_halt_resume();
        clr = 1;
        tick(1);
        clr = 0;
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL clr_over_commit got=%0d exp=0", cycle_cnt); end
        tick(4);
        Halt = 1;
        #1;
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL syscall_commit got=%0b exp=0", commit); end
        tick(1);
        checks++; if (run_state !== 2'd3) begin errors++; $display("FAIL halt_state got=%0d exp=3", run_state); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_flag got=%0b exp=1", halted); end
        checks++; if (halt_cnt !== 32'd1) begin errors++; $display("FAIL halt_cnt got=%0d exp=1", halt_cnt); end
        tick(3);
        checks++; if (cycle_cnt !== 32'd4) begin errors++; $display("FAIL halt_frozen got=%0d exp=4", cycle_cnt); end
        step = 1;
        #1;
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL halt_step_commit got=%0b exp=0", commit); end
        tick(1);
        step = 0;
        checks++; if (run_state !== 2'd3) begin errors++; $display("FAIL halt_step_state got=%0d exp=3", run_state); end
        go = 1;
        #1;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL resume_commit got=%0b exp=1", commit); end
        tick(1);
        go = 0;
        Halt = 0;
        checks++; if (run_state !== 2'd1) begin errors++; $display("FAIL resume_state got=%0d exp=1", run_state); end
        checks++; if (cycle_cnt !== 32'd5) begin errors++; $display("FAIL resume_cycles got=%0d exp=5", cycle_cnt); end
        checks++; if (halt_cnt !== 32'd1) begin errors++; $display("FAIL resume_halt_cnt got=%0d exp=1", halt_cnt); end
    endtask

    task automatic test_single_step();
        int commits;
        do_reset();
        step_mode = 1;
        press_go();
        checks++; if (run_state !== 2'd2) begin errors++; $display("FAIL pause_state got=%0d exp=2", run_state); end
        commits = 0;
        step = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (commit === 1'b1) commits++;
            tick(1);
        end
        step = 0;
        checks++; if (commits !== 1) begin errors++; $display("FAIL held_step_commits got=%0d exp=1", commits); end
        checks++; if (cycle_cnt !== 32'd1) begin errors++; $display("FAIL held_step_cycles got=%0d exp=1", cycle_cnt); end
        tick(1);
        for (int i = 0; i < 3; i++) begin
            step = 1;
            tick(1);
            step = 0;
            tick(1);
        end
        checks++; if (cycle_cnt !== 32'd4) begin errors++; $display("FAIL three_steps got=%0d exp=4", cycle_cnt); end
        step = 1;
        Halt = 1;
        #1;
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL pause_halt_commit got=%0b exp=0", commit); end
        tick(1);
        step = 0;
        checks++; if (run_state !== 2'd3) begin errors++; $display("FAIL pause_to_halt got=%0d exp=3", run_state); end
        go = 1;
        tick(1);
        go = 0;
        Halt = 0;
        checks++; if (run_state !== 2'd2) begin errors++; $display("FAIL resume_to_pause got=%0d exp=2", run_state); end
        checks++; if (cycle_cnt !== 32'd5) begin errors++; $display("FAIL resume_pause_cycles got=%0d exp=5", cycle_cnt); end
    endtask

    task automatic apply_flag_pattern();
        TargettoPC = 1; tick(2); TargettoPC = 0;
        RStoPC = 1; tick(1); RStoPC = 0;
        Branch = 1; Z = 1; tick(3);
        Z = 0; tick(2);
        Branch = 0;
    endtask

    task automatic test_jump_branch_counts();
        do_reset();
        press_go();
        apply_flag_pattern();
        checks++; if (jump_cnt !== 32'd3) begin errors++; $display("FAIL run_jumps got=%0d exp=3", jump_cnt); end
        checks++; if (branch_cnt !== 32'd3) begin errors++; $display("FAIL run_branches got=%0d exp=3", branch_cnt); end
        checks++; if (cycle_cnt !== 32'd8) begin errors++; $display("FAIL run_pattern_cycles got=%0d exp=8", cycle_cnt); end
        step_mode = 1;
        tick(1);
        checks++; if (run_state !== 2'd2) begin errors++; $display("FAIL run_to_pause got=%0d exp=2", run_state); end
        apply_flag_pattern();
        checks++; if (jump_cnt !== 32'd3) begin errors++; $display("FAIL pause_jumps got=%0d exp=3", jump_cnt); end
        checks++; if (branch_cnt !== 32'd3) begin errors++; $display("FAIL pause_branches got=%0d exp=3", branch_cnt); end
        checks++; if (cycle_cnt !== 32'd9) begin errors++; $display("FAIL pause_cycles got=%0d exp=9", cycle_cnt); end
        step_mode = 0;
        go = 1;
        step = 1;
        #1;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL go_step_commit got=%0b exp=1", commit); end
        tick(1);
        go = 0;
        step = 0;
        checks++; if (run_state !== 2'd1) begin errors++; $display("FAIL go_step_state got=%0d exp=1", run_state); end
    endtask

    task automatic test_saturation();
        do_reset();
        press_go();
        tick(20);
        checks++; if (cycle_cnt4 !== 4'd15) begin errors++; $display("FAIL sat4_cycles got=%0d exp=15", cycle_cnt4); end
        checks++; if (cycle_cnt !== 32'd20) begin errors++; $display("FAIL wide_cycles got=%0d exp=20", cycle_cnt); end
        clr = 1;
        #1;
        checks++; if (commit4 !== 1'b1) begin errors++; $display("FAIL clr_cycle_commit got=%0b exp=1", commit4); end
        tick(1);
        clr = 0;
        checks++; if (cycle_cnt4 !== 4'd0) begin errors++; $display("FAIL sat4_clr got=%0d exp=0", cycle_cnt4); end
        checks++; if (run_state4 !== 2'd1) begin errors++; $display("FAIL clr_keeps_state got=%0d exp=1", run_state4); end
    endtask

    task automatic test_async_reset();
        tick(3);
        #2;
        rst_n = 0;
        #1;
        checks++; if (run_state !== 2'd0) begin errors++; $display("FAIL async_state got=%0d exp=0", run_state); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL async_commit got=%0b exp=0", commit); end
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL async_cycles got=%0d exp=0", cycle_cnt); end
        tick(1);
        rst_n = 1;
        tick(1);
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset_and_run();
        test_halt_resume();
        test_single_step();
        test_jump_branch_counts();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
